// File: rtl/arm_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arm_mem_pkg                                                  |
// | Description : Shared definitions for the ARM memory-port arbiter: FSM      |
// |               state encoding, requester IDs, memory region map and the     |
// |               big-endian byte-lane helpers.                                |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package arm_mem_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_MERGE  = 2'd2;
  localparam logic [1:0] c_ST_RESP   = 2'd3;

  // Requester IDs; also the bit index into the req/gnt vectors
  localparam logic c_REQ_IF = 1'b0;
  localparam logic c_REQ_LS = 1'b1;

  // Memory region map
  localparam logic [31:0] c_DATA_BASE = 32'h1000_0000;
  localparam logic [31:0] c_DATA_SIZE = 32'h0000_0100;
  localparam logic [31:0] c_TEXT_BASE = 32'h0000_0000;
  localparam logic [31:0] c_TEXT_SIZE = 32'h0000_0100;

  // Big-endian lane extract: offset 0 is the most significant byte.
  function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] off);
    case (off)
      2'd0:    lane_get = word[31:24];
      2'd1:    lane_get = word[23:16];
      2'd2:    lane_get = word[15:8];
      default: lane_get = word[7:0];
    endcase
  endfunction

  // Big-endian lane replace: returns word with the selected byte swapped out.
  function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] off,
                                           input logic [7:0] data);
    lane_put = word;
    case (off)
      2'd0:    lane_put[31:24] = data;
      2'd1:    lane_put[23:16] = data;
      2'd2:    lane_put[15:8]  = data;
      default: lane_put[7:0]   = data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arm_rr_arbiter                                               |
// | Description : Two-way round-robin arbiter with a registered pointer.       |
// |               A lone requester is always granted; on contention the        |
// |               pointer side wins and the pointer moves to the other side.   |
// | Ports       : clk, reset (async, active-high), req[1:0], advance           |
// |               (grant consumed this cycle), gnt[1:0] (one-hot grant)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module arm_rr_arbiter
  import arm_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Side that wins the next contended grant
  logic r_ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_ptr == c_REQ_IF) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // The pointer only moves when a contended grant is actually taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= c_REQ_IF;
    end else if (advance && (&req)) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arm_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arm_mem_arbiter                                              |
// | Description : Shares one word-wide memory port between instruction fetch   |
// |               (IF, word read) and load/store (LS, word/byte read/write).   |
// |               Round-robin grant, request capture, alignment check, and     |
// |               read-modify-write for byte stores (big-endian lanes).        |
// | Ports       : clk, reset (async, active-high)                              |
// |               IF : if_req, if_addr -> if_done, if_rdata, if_fault          |
// |               LS : ls_req, ls_addr, ls_we, ls_byte, ls_wdata               |
// |                    -> ls_done, ls_rdata, ls_fault                          |
// |               MEM: mem_addr, mem_wdata, mem_we <- mem_rdata, mem_excpt     |
// |               busy (not IDLE)                                              |
// | Options     : ARM_MEM_ARB_STATS_EN adds stat_if_grants, stat_ls_grants,    |
// |               stat_faults (16-bit saturating counters)                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module arm_mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_fault,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_we,
  input  logic              ls_byte,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_excpt,
  output logic              busy
`ifdef ARM_MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_if_grants,
  output logic [15:0]       stat_ls_grants,
  output logic [15:0]       stat_faults
`endif
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        w_gnt;
  logic              w_advance;
  logic              w_misalign;
  logic              r_sel;      // requester that owns the current transaction
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_byte;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_merge;    // word read in ACCESS for a byte store
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;
  logic [ADDR_W-1:0] w_addr_al;

  arm_rr_arbiter u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({ls_req, if_req}),
    .advance (w_advance),
    .gnt     (w_gnt)
  );

  assign w_advance = (r_state == c_ST_IDLE) && (|w_gnt);
  assign w_addr_al = {r_addr[ADDR_W-1:2], 2'b00};

  // Fetches are always word accesses; byte LS accesses can never misalign.
  always_comb begin
    if (w_gnt[c_REQ_LS]) begin
      w_misalign = !ls_byte && (ls_addr[1:0] != 2'b00);
    end else begin
      w_misalign = (if_addr[1:0] != 2'b00);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_advance) begin
          w_state_nxt = w_misalign ? c_ST_RESP : c_ST_ACCESS;
        end
      end
      c_ST_ACCESS: begin
        w_state_nxt = (!mem_excpt && r_we && r_byte) ? c_ST_MERGE : c_ST_RESP;
      end
      c_ST_MERGE: w_state_nxt = c_ST_RESP;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Request capture and read-data path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel   <= c_REQ_IF;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_advance) begin
            r_fault <= w_misalign;
            r_rdata <= '0;
            if (w_gnt[c_REQ_LS]) begin
              r_sel   <= c_REQ_LS;
              r_addr  <= ls_addr;
              r_we    <= ls_we;
              r_byte  <= ls_byte;
              r_wdata <= ls_wdata;
            end else begin
              r_sel   <= c_REQ_IF;
              r_addr  <= if_addr;
              r_we    <= 1'b0;
              r_byte  <= 1'b0;
              r_wdata <= '0;
            end
          end
        end
        c_ST_ACCESS: begin
          if (mem_excpt) begin
            r_fault <= 1'b1;
            r_rdata <= '0;
          end else if (!r_we) begin
            r_rdata <= r_byte ? {24'd0, lane_get(mem_rdata, r_addr[1:0])} : mem_rdata;
          end else if (r_byte) begin
            r_merge <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: decoded from registered state so an async reset drops mem_we at once.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if_done   = 1'b0;
    if_rdata  = '0;
    if_fault  = 1'b0;
    ls_done   = 1'b0;
    ls_rdata  = '0;
    ls_fault  = 1'b0;
    busy      = (r_state != c_ST_IDLE);
    case (r_state)
      c_ST_ACCESS: begin
        mem_addr = w_addr_al;
        if (r_we && !r_byte && !mem_excpt) begin
          mem_we    = 1'b1;
          mem_wdata = r_wdata;
        end
      end
      c_ST_MERGE: begin
        mem_addr  = w_addr_al;
        mem_we    = 1'b1;
        mem_wdata = lane_put(r_merge, r_addr[1:0], r_wdata[7:0]);
      end
      c_ST_RESP: begin
        if (r_sel == c_REQ_LS) begin
          ls_done  = 1'b1;
          ls_rdata = r_rdata;
          ls_fault = r_fault;
        end else begin
          if_done  = 1'b1;
          if_rdata = r_rdata;
          if_fault = r_fault;
        end
      end
      default: ;
    endcase
  end

`ifdef ARM_MEM_ARB_STATS_EN
  logic [15:0] r_stat_if;
  logic [15:0] r_stat_ls;
  logic [15:0] r_stat_flt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_if  <= '0;
      r_stat_ls  <= '0;
      r_stat_flt <= '0;
    end else if (r_state == c_ST_RESP) begin
      if (r_sel == c_REQ_LS) begin
        if (r_stat_ls != 16'hFFFF) r_stat_ls <= r_stat_ls + 16'd1;
      end else begin
        if (r_stat_if != 16'hFFFF) r_stat_if <= r_stat_if + 16'd1;
      end
      if (r_fault && (r_stat_flt != 16'hFFFF)) r_stat_flt <= r_stat_flt + 16'd1;
    end
  end

  assign stat_if_grants = r_stat_if;
  assign stat_ls_grants = r_stat_ls;
  assign stat_faults    = r_stat_flt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arm_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arm_mem_arbiter                                           |
// | Description : Self-checking bench for arm_mem_arbiter: directed vector     |
// |               table, contention and reset-during-merge sequences, then     |
// |               random traffic against a transaction-level memory model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_arm_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we, ls_byte;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_done, if_fault, ls_done, ls_fault, mem_we, mem_excpt, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef ARM_MEM_ARB_STATS_EN
  logic [15:0] stat_if_grants, stat_ls_grants, stat_faults;
`endif

  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_fault(if_fault),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_byte(ls_byte), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_excpt(mem_excpt), .busy(busy)
`ifdef ARM_MEM_ARB_STATS_EN
    , .stat_if_grants(stat_if_grants), .stat_ls_grants(stat_ls_grants), .stat_faults(stat_faults)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- memory model (TEXT 0x0..0xFF, DATA 0x1000_0000..0xFF) ----
  logic [31:0] mem_data [0:63];
  logic [31:0] mem_text [0:63];
  logic [31:0] sh_data  [0:63];
  logic [31:0] sh_text  [0:63];
  logic        init_req;

  function automatic logic [31:0] init_data(input int i);
    return {8'hD0, 8'(i), 8'hC0, 8'(i)};
  endfunction
  function automatic logic [31:0] init_text(input int i);
    return {8'hE3, 8'hA0, 8'h00, 8'(i)};
  endfunction
  function automatic bit in_data(input logic [31:0] a);
    return (a >= 32'h1000_0000) && (a < 32'h1000_0100);
  endfunction
  function automatic bit in_text(input logic [31:0] a);
    return a < 32'h0000_0100;
  endfunction

  always_comb begin
    mem_excpt = 1'b1;
    mem_rdata = 32'h0;
    if (in_data(mem_addr)) begin
      mem_excpt = 1'b0;
      mem_rdata = mem_data[mem_addr[7:2]];
    end else if (in_text(mem_addr)) begin
      mem_excpt = 1'b0;
      mem_rdata = mem_text[mem_addr[7:2]];
    end
  end

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 64; i++) begin
        mem_data[i] <= init_data(i);
        mem_text[i] <= init_text(i);
      end
    end else if (mem_we && !mem_excpt) begin
      if (in_data(mem_addr)) mem_data[mem_addr[7:2]] <= mem_wdata;
      else                   mem_text[mem_addr[7:2]] <= mem_wdata;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit turn_ls;   // whose turn it is on the next contended grant

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    turn_ls = 1'b0;
    tick();
  endtask

  // Transaction-level model: result of one access, updating the shadow memory.
  task automatic model(input bit we, input bit byt, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output bit flt,
                       output int wen, output bit rd_valid);
    logic [31:0] w, nw;
    int idx, sh;
    idx = int'(a[7:2]);
    sh  = 8 * (3 - int'(a[1:0]));
    w   = in_data(a) ? sh_data[idx] : (in_text(a) ? sh_text[idx] : 32'h0);
    rd = 32'h0; flt = 1'b0; wen = 0; rd_valid = 1'b1; lat = 2;
    if (!byt && a[1:0] != 2'b00) begin
      lat = 1; flt = 1'b1; rd_valid = 1'b0;
    end else if (!in_data(a) && !in_text(a)) begin
      lat = 2; flt = 1'b1;
    end else if (!we) begin
      lat = 2;
      rd  = byt ? ((w >> sh) & 32'hFF) : w;
    end else begin
      rd_valid = 1'b0;
      wen = 1;
      lat = byt ? 3 : 2;
      nw  = byt ? ((w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh)) : wd;
      if (in_data(a)) sh_data[idx] = nw;
      else            sh_text[idx] = nw;
    end
  endtask

  // Drive one or both requests; record when each done arrives (0 = never).
  task automatic run_txn(input bit i_on, input logic [31:0] ia,
                         input bit l_on, input bit we, input bit byt,
                         input logic [31:0] la, input logic [31:0] wd,
                         output int t_if, output logic [31:0] rd_if, output bit f_if,
                         output int t_ls, output logic [31:0] rd_ls, output bit f_ls,
                         output int we_n);
    t_if = 0; rd_if = 32'h0; f_if = 1'b0;
    t_ls = 0; rd_ls = 32'h0; f_ls = 1'b0;
    we_n = 0;
    if_req = i_on; if_addr = ia;
    ls_req = l_on; ls_addr = la; ls_we = we; ls_byte = byt; ls_wdata = wd;
    for (int t = 1; t <= 30 && (if_req || ls_req); t++) begin
      tick();
      if (mem_we) we_n++;
      if (if_done && ls_done) chk("done_overlap", 32'(ls_done), 32'(0));
      if (if_done && t_if == 0) begin
        t_if = t; rd_if = if_rdata; f_if = if_fault; if_req = 1'b0;
      end
      if (ls_done && t_ls == 0) begin
        t_ls = t; rd_ls = ls_rdata; f_ls = ls_fault; ls_req = 1'b0;
      end
    end
    if (if_req || ls_req) begin
      chk("txn_timeout", 32'(1), 32'(0));
      if_req = 1'b0; ls_req = 1'b0;
    end
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    logic [1:0]  off;
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)      base = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4;
    else if (r < 8) base = 32'($urandom_range(0, 63)) * 4;
    else            base = 32'h2000_0000 + 32'($urandom_range(0, 15)) * 4;
    off = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return base | {30'd0, off};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          if_on;  logic [31:0] if_a;
    bit          ls_on;  bit we; bit byt; logic [31:0] ls_a; logic [31:0] wd;
    int          e_tif;  logic [31:0] e_rdif; bit e_fif;
    int          e_tls;  logic [31:0] e_rdls; bit e_fls;
    bit          chk_rd; int e_we;
  } vec_t;

  vec_t vecs [14];

  // ---------------- main ----------------
  initial begin : main
    int t_if, t_ls, we_n, lat_a, lat_b, wen_a, wen_b;
    logic [31:0] rd_if, rd_ls, rd_a, rd_b;
    bit f_if, f_ls, flt_a, flt_b, rv_a, rv_b;

    vecs[0]  = '{0, 32'h0, 1, 1, 0, 32'h1000_0010, 32'hDEAD_BEEF, 0, 32'h0, 0, 2, 32'h0,         0, 0, 1};
    vecs[1]  = '{0, 32'h0, 1, 0, 0, 32'h1000_0010, 32'h0,         0, 32'h0, 0, 2, 32'hDEAD_BEEF, 0, 1, 0};
    vecs[2]  = '{0, 32'h0, 1, 1, 0, 32'h1000_0010, 32'h1122_3344, 0, 32'h0, 0, 2, 32'h0,         0, 0, 1};
    vecs[3]  = '{0, 32'h0, 1, 1, 1, 32'h1000_0012, 32'h0000_00AA, 0, 32'h0, 0, 3, 32'h0,         0, 0, 1};
    vecs[4]  = '{0, 32'h0, 1, 0, 0, 32'h1000_0010, 32'h0,         0, 32'h0, 0, 2, 32'h1122_AA44, 0, 1, 0};
    vecs[5]  = '{0, 32'h0, 1, 0, 1, 32'h1000_0012, 32'h0,         0, 32'h0, 0, 2, 32'h0000_00AA, 0, 1, 0};
    vecs[6]  = '{0, 32'h0, 1, 0, 1, 32'h1000_0013, 32'h0,         0, 32'h0, 0, 2, 32'h0000_0044, 0, 1, 0};
    vecs[7]  = '{0, 32'h0, 1, 0, 1, 32'h1000_0010, 32'h0,         0, 32'h0, 0, 2, 32'h0000_0011, 0, 1, 0};
    vecs[8]  = '{0, 32'h0, 1, 0, 0, 32'h1000_0002, 32'h0,         0, 32'h0, 0, 1, 32'h0,         1, 0, 0};
    vecs[9]  = '{1, 32'h2000_0000, 0, 0, 0, 32'h0, 32'h0,         2, 32'h0, 1, 0, 32'h0,         0, 1, 0};
    vecs[10] = '{1, 32'h0000_0004, 0, 0, 0, 32'h0, 32'h0,         2, 32'hE3A0_0001, 0, 0, 32'h0, 0, 1, 0};
    vecs[11] = '{0, 32'h0, 1, 1, 1, 32'h1000_0011, 32'hFFFF_FF5A, 0, 32'h0, 0, 3, 32'h0,         0, 0, 1};
    vecs[12] = '{0, 32'h0, 1, 0, 0, 32'h1000_0010, 32'h0,         0, 32'h0, 0, 2, 32'h115A_AA44, 0, 1, 0};
    vecs[13] = '{0, 32'h0, 1, 1, 1, 32'h2000_0001, 32'h0000_0077, 0, 32'h0, 0, 2, 32'h0,         1, 1, 0};

    for (int i = 0; i < 64; i++) begin
      sh_data[i] = init_data(i);
      sh_text[i] = init_text(i);
    end
    if_req = 0; ls_req = 0; ls_we = 0; ls_byte = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    reset = 1'b1; init_req = 1'b1; turn_ls = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_if_done",   32'(if_done),  32'(0));
    chk("rst_ls_done",   32'(ls_done),  32'(0));
    chk("rst_if_rdata",  if_rdata,      32'h0);
    chk("rst_ls_rdata",  ls_rdata,      32'h0);
    chk("rst_faults",    32'({if_fault, ls_fault}), 32'(0));
    chk("rst_mem_addr",  mem_addr,      32'h0);
    chk("rst_mem_wdata", mem_wdata,     32'h0);
    chk("rst_mem_we",    32'(mem_we),   32'(0));
    chk("rst_busy",      32'(busy),     32'(0));
    init_req = 1'b0;
    reset = 1'b0;
    tick();

    // Directed table
    foreach (vecs[i]) begin
      run_txn(vecs[i].if_on, vecs[i].if_a, vecs[i].ls_on, vecs[i].we, vecs[i].byt,
              vecs[i].ls_a, vecs[i].wd, t_if, rd_if, f_if, t_ls, rd_ls, f_ls, we_n);
      if (vecs[i].if_on) model(1'b0, 1'b0, vecs[i].if_a, 32'h0, lat_a, rd_a, flt_a, wen_a, rv_a);
      else               model(vecs[i].we, vecs[i].byt, vecs[i].ls_a, vecs[i].wd, lat_a, rd_a, flt_a, wen_a, rv_a);
      chk($sformatf("vec%0d_if_lat", i), 32'(t_if), 32'(vecs[i].e_tif));
      chk($sformatf("vec%0d_ls_lat", i), 32'(t_ls), 32'(vecs[i].e_tls));
      chk($sformatf("vec%0d_we_cyc", i), 32'(we_n), 32'(vecs[i].e_we));
      if (vecs[i].if_on) chk($sformatf("vec%0d_if_fault", i), 32'(f_if), 32'(vecs[i].e_fif));
      else               chk($sformatf("vec%0d_ls_fault", i), 32'(f_ls), 32'(vecs[i].e_fls));
      if (vecs[i].chk_rd && vecs[i].if_on)  chk($sformatf("vec%0d_if_rdata", i), rd_if, vecs[i].e_rdif);
      if (vecs[i].chk_rd && !vecs[i].if_on) chk($sformatf("vec%0d_ls_rdata", i), rd_ls, vecs[i].e_rdls);
    end
    chk("mem_after_table", mem_data[4], 32'h115A_AA44);

    // Both requesters held for 12 cycles: IF, LS, IF, LS at +2, +5, +8, +11
    begin : starve
      int seq_t [4];
      int seq_s [4];
      int n_done;
      int exp_t [4];
      exp_t = '{2, 5, 8, 11};
      n_done = 0;
      apply_reset();
      if_req = 1; if_addr = 32'h0000_0008;
      ls_req = 1; ls_we = 0; ls_byte = 0; ls_addr = 32'h1000_0014; ls_wdata = 0;
      for (int t = 1; t <= 12; t++) begin
        tick();
        if (if_done && ls_done) chk("starve_overlap", 32'(1), 32'(0));
        if ((if_done || ls_done) && n_done < 4) begin
          seq_t[n_done] = t;
          seq_s[n_done] = ls_done ? 1 : 0;
          if (n_done == 0) chk("starve_if_rdata", if_rdata, init_text(2));
          if (n_done == 1) chk("starve_ls_rdata", ls_rdata, init_data(5));
          n_done++;
        end
      end
      if_req = 0; ls_req = 0;
      chk("starve_count", 32'(n_done), 32'(4));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("starve_side%0d", k), (k < n_done) ? 32'(seq_s[k]) : 32'hFFFF_FFFF, 32'(k % 2));
        chk($sformatf("starve_time%0d", k), (k < n_done) ? 32'(seq_t[k]) : 32'hFFFF_FFFF, 32'(exp_t[k]));
      end
      tick(); tick();
      chk("starve_idle_busy", 32'(busy), 32'(0));
    end

    // Reset asserted while the byte-store write is on the port
    begin : rst_merge
      bit seen_done;
      seen_done = 1'b0;
      apply_reset();
      ls_req = 1; ls_we = 1; ls_byte = 1; ls_addr = 32'h1000_0021; ls_wdata = 32'h77;
      tick();
      tick();
      chk("merge_we_pre_reset", 32'(mem_we), 32'(1));
      #1 reset = 1'b1;
      #1;
      chk("merge_we_on_reset", 32'(mem_we), 32'(0));
      chk("merge_busy_on_reset", 32'(busy), 32'(0));
      ls_req = 0;
      tick();
      if (ls_done) seen_done = 1'b1;
      reset = 1'b0;
      turn_ls = 1'b0;
      for (int t = 0; t < 4; t++) begin
        tick();
        if (ls_done) seen_done = 1'b1;
      end
      chk("merge_no_done", 32'(seen_done), 32'(0));
      chk("merge_mem_kept", mem_data[8], init_data(8));
    end

    // Random traffic against the transaction-level model
    for (int it = 0; it < 80; it++) begin
      int mode;
      bit i_on, l_on, we, byt, ls_first;
      logic [31:0] ia, la, wd;
      int e_tif, e_tls;
      mode = $urandom_range(0, 2);
      i_on = (mode != 1);
      l_on = (mode != 0);
      ia   = rand_addr();
      la   = rand_addr();
      we   = 1'($urandom_range(0, 1));
      byt  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if (i_on && l_on) begin
        ls_first = turn_ls;
        turn_ls  = !turn_ls;
      end else begin
        ls_first = l_on;
      end
      lat_b = 0; wen_b = 0; rd_b = 0; flt_b = 0; rv_b = 0;
      if (ls_first) begin
        model(we, byt, la, wd, lat_a, rd_a, flt_a, wen_a, rv_a);
        if (i_on) model(1'b0, 1'b0, ia, 32'h0, lat_b, rd_b, flt_b, wen_b, rv_b);
        e_tls = lat_a;
        e_tif = i_on ? lat_a + 1 + lat_b : 0;
      end else begin
        model(1'b0, 1'b0, ia, 32'h0, lat_a, rd_a, flt_a, wen_a, rv_a);
        if (l_on) model(we, byt, la, wd, lat_b, rd_b, flt_b, wen_b, rv_b);
        e_tif = lat_a;
        e_tls = l_on ? lat_a + 1 + lat_b : 0;
      end
      run_txn(i_on, ia, l_on, we, byt, la, wd, t_if, rd_if, f_if, t_ls, rd_ls, f_ls, we_n);
      chk($sformatf("rnd%0d_if_lat", it), 32'(t_if), 32'(e_tif));
      chk($sformatf("rnd%0d_ls_lat", it), 32'(t_ls), 32'(e_tls));
      chk($sformatf("rnd%0d_we_cyc", it), 32'(we_n), 32'(wen_a + wen_b));
      if (ls_first) begin
        chk($sformatf("rnd%0d_ls_fault", it), 32'(f_ls), 32'(flt_a));
        if (rv_a) chk($sformatf("rnd%0d_ls_rdata", it), rd_ls, rd_a);
        if (i_on) chk($sformatf("rnd%0d_if_fault", it), 32'(f_if), 32'(flt_b));
        if (i_on && rv_b) chk($sformatf("rnd%0d_if_rdata", it), rd_if, rd_b);
      end else begin
        chk($sformatf("rnd%0d_if_fault", it), 32'(f_if), 32'(flt_a));
        if (rv_a) chk($sformatf("rnd%0d_if_rdata", it), rd_if, rd_a);
        if (l_on) chk($sformatf("rnd%0d_ls_fault", it), 32'(f_ls), 32'(flt_b));
        if (l_on && rv_b) chk($sformatf("rnd%0d_ls_rdata", it), rd_ls, rd_b);
      end
      if (l_on && in_data(la)) chk($sformatf("rnd%0d_mem", it), mem_data[la[7:2]], sh_data[la[7:2]]);
      if (l_on && in_text(la)) chk($sformatf("rnd%0d_mem", it), mem_text[la[7:2]], sh_text[la[7:2]]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
